// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives PC stall/jump controls, issues one fetch at a
// time, buffers one instruction for decode and squashes fetches overtaken by a redirect.
module fetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    output logic        pc_stall,
    output logic        pc_jmp,
    output logic        pc_rel,
    output logic [31:0] pc_nxt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    input  logic        trap,
    input  logic [31:0] trap_vec,
    input  logic        jalr,
    input  logic [31:0] jalr_tgt,
    input  logic        br_taken,
    input  logic [31:0] br_tgt,
    output logic        misalign
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state_reg, state_next;
    logic        kill_reg, kill_next;
    logic [31:0] fpc_reg, fpc_next;
    logic [31:0] ibuf_reg, ibuf_next;
    logic [31:0] ipc_reg, ipc_next;

    logic        redir;
    logic        grant;
    logic [31:0] sel_tgt;

    // Redirect arbitration: trap outranks jalr, which outranks a taken branch.
    always_comb begin
        redir   = 1'b0;
        sel_tgt = 32'd0;
        if (!rst) begin
            if (trap) begin
                redir   = 1'b1;
                sel_tgt = trap_vec;
            end else if (jalr) begin
                redir   = 1'b1;
                sel_tgt = jalr_tgt;
            end else if (br_taken) begin
                redir   = 1'b1;
                sel_tgt = br_tgt;
            end
        end
    end

    assign pc_nxt    = {sel_tgt[31:2], 2'b00};
    assign misalign  = redir & (sel_tgt[1:0] != 2'b00);
    assign pc_rel    = 1'b0;
    assign imem_addr = pc_cur;
    assign imem_req  = ~rst & (state_reg == REQ);
    assign grant     = imem_req & imem_gnt;
    assign pc_jmp    = redir;
    assign pc_stall  = ~(grant | redir);
    // A redirect squashes the buffered (younger) instruction in the same cycle.
    assign if_valid  = ~rst & (state_reg == HOLD) & ~redir;
    assign if_instr  = ibuf_reg;
    assign if_pc     = ipc_reg;

    always_comb begin
        state_next = state_reg;
        kill_next  = kill_reg;
        fpc_next   = fpc_reg;
        ibuf_next  = ibuf_reg;
        ipc_next   = ipc_reg;
        case (state_reg)
            IDLE: state_next = REQ;
            REQ: begin
                if (grant) begin
                    fpc_next   = pc_cur;
                    kill_next  = redir;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (kill_reg || redir) begin
                        kill_next  = 1'b0;
                        state_next = REQ;
                    end else begin
                        ibuf_next  = imem_rdata;
                        ipc_next   = fpc_reg;
                        state_next = HOLD;
                    end
                end else if (redir) begin
                    kill_next = 1'b1;
                end
            end
            HOLD: begin
                if (redir || if_ready) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            kill_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            kill_reg  <= kill_next;
        end
    end

    // Datapath registers carry no reset; they are only observed once qualified by state.
    always_ff @(posedge clk) begin
        fpc_reg  <= fpc_next;
        ibuf_reg <= ibuf_next;
        ipc_reg  <= ipc_next;
    end

endmodule
